// File: rtl/switch_bounce_emulator.sv
// Mechanical switch emulator: turns a clean level command into a bouncing
// contact waveform with LFSR-driven glitch widths, then holds the final level.
module switch_bounce_emulator #(
    parameter int          G          = 2,
    parameter int          SETTLE_CYC = 16,
    parameter logic [7:0]  SEED       = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic       cmd_level,
    input  logic [3:0] bounce_num,
    output logic       cmd_ready,
    output logic       sw_out,
    output logic       busy,
    output logic       done
);

    localparam int HW = $clog2(SETTLE_CYC) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOUNCE = 2'd1,
        SETTLE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    lfsr_q, lfsr_d;
    logic [G:0]    seg_q, seg_d;
    logic [4:0]    rem_q, rem_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          sw_q, sw_d;
    logic          done_q, done_d;

    logic [G:0]    seg_load;
    logic [HW-1:0] hold_load;

    // Taps 8,6,5,4 of x^8+x^6+x^5+x^4+1; free-running in every state.
    assign lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign seg_load  = (G+1)'(lfsr_q[G-1:0]) + (G+1)'(1);
    assign hold_load = HW'(SETTLE_CYC);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        seg_d   = seg_q;
        rem_d   = rem_q;
        hold_d  = hold_q;
        sw_d    = sw_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_level == sw_q) begin
                        state_d = SETTLE;
                        hold_d  = hold_load;
                    end else if (bounce_num == 4'd0) begin
                        sw_d    = cmd_level;
                        state_d = SETTLE;
                        hold_d  = hold_load;
                    end else begin
                        sw_d    = cmd_level;
                        rem_d   = {bounce_num, 1'b0};
                        seg_d   = seg_load;
                        state_d = BOUNCE;
                    end
                end
            end
            BOUNCE: begin
                if (seg_q > (G+1)'(1)) begin
                    seg_d = seg_q - (G+1)'(1);
                end else begin
                    // rem is even on entry, so the last toggle lands on the commanded level.
                    sw_d  = ~sw_q;
                    rem_d = rem_q - 5'd1;
                    seg_d = seg_load;
                    if (rem_q == 5'd1) begin
                        state_d = SETTLE;
                        hold_d  = hold_load;
                    end
                end
            end
            SETTLE: begin
                hold_d = hold_q - HW'(1);
                if (hold_q == HW'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= IDLE;
            lfsr_q  <= SEED;
            seg_q   <= '0;
            rem_q   <= '0;
            hold_q  <= '0;
            sw_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            seg_q   <= seg_d;
            rem_q   <= rem_d;
            hold_q  <= hold_d;
            sw_q    <= sw_d;
            done_q  <= done_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign sw_out    = sw_q;
    assign done      = done_q;

endmodule

// File: tb/tb_switch_bounce_emulator.sv
// Directed bench for switch_bounce_emulator: reset, clean edge, bounce timing
// against a reference LFSR, ignored commands, async reset and a debouncer loop.
module tb_switch_bounce_emulator;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_level;
    logic [3:0] bounce_num;
    logic       cmd_ready;
    logic       sw_out;
    logic       busy;
    logic       done;

    int tests = 0;
    int fails = 0;

    switch_bounce_emulator dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_level  (cmd_level),
        .bounce_num (bounce_num),
        .cmd_ready  (cmd_ready),
        .sw_out     (sw_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] adv(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Reference LFSR: value seen at a negedge is the one the next rising edge uses.
    logic [7:0] m_lfsr;
    always @(posedge clk or negedge reset) begin
        if (!reset) m_lfsr <= 8'hA5;
        else        m_lfsr <= adv(m_lfsr);
    end

    // Debouncer model: level follows sw after 8 consecutive differing cycles.
    logic       db_level;
    logic [2:0] db_cnt;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_level <= 1'b0;
            db_cnt   <= 3'd0;
        end else if (sw_out != db_level) begin
            if (db_cnt == 3'd7) begin
                db_level <= sw_out;
                db_cnt   <= 3'd0;
            end else begin
                db_cnt <= db_cnt + 3'd1;
            end
        end else begin
            db_cnt <= 3'd0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int        lens [6];
        int        tog  [6];
        int        t, nt, done_at, ntr, last_change, seg_idx, w, db_tog;
        logic [7:0] vv;
        logic       prev, exp_sw, lvl, db_prev;

        cmd_valid  = 1'b0;
        cmd_level  = 1'b0;
        bounce_num = 4'd0;
        reset      = 1'b0;

        // Reset held for three cycles
        repeat (3) begin
            @(negedge clk);
            check("rst_sw",    32'(sw_out),    32'd0);
            check("rst_ready", 32'(cmd_ready), 32'd1);
            check("rst_busy",  32'(busy),      32'd0);
            check("rst_done",  32'(done),      32'd0);
        end
        reset = 1'b1;
        #1 check("rst_lfsr", 32'(dut.lfsr_q), 32'hA5);

        // Clean edge: level 1, no bounce
        cmd_valid = 1'b1; cmd_level = 1'b1; bounce_num = 4'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("clean_sw0",    32'(sw_out),    32'd1);
        check("clean_busy0",  32'(busy),      32'd1);
        check("clean_ready0", 32'(cmd_ready), 32'd0);
        check("clean_done0",  32'(done),      32'd0);
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            check("clean_sw",   32'(sw_out), 32'd1);
            check("clean_done", 32'(done),   32'(j == 16));
        end
        check("clean_ready", 32'(cmd_ready), 32'd1);

        // Same level, then an opposite command offered while busy
        cmd_valid = 1'b1; cmd_level = 1'b1; bounce_num = 4'd0;
        @(negedge clk);
        cmd_level = 1'b0; bounce_num = 4'd5;
        check("same_sw0",   32'(sw_out), 32'd1);
        check("same_busy0", 32'(busy),   32'd1);
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            check("same_sw",   32'(sw_out), 32'd1);
            check("same_done", 32'(done),   32'(j == 16));
            check("same_busy", 32'(busy),   32'(j < 16));
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        check("ignored_sw",    32'(sw_out),    32'd1);
        check("ignored_ready", 32'(cmd_ready), 32'd1);

        // Return to 0 with a clean edge
        cmd_valid = 1'b1; cmd_level = 1'b0; bounce_num = 4'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            check("lo_done", 32'(done), 32'(j == 16));
        end
        check("lo_sw", 32'(sw_out), 32'd0);

        // Bounce: level 1, three pairs; segment lengths from the reference LFSR
        cmd_valid = 1'b1; cmd_level = 1'b1; bounce_num = 4'd3;
        vv = m_lfsr;
        t  = 0;
        for (int s = 0; s < 6; s++) begin
            lens[s] = int'(vv[1:0]) + 1;
            repeat (lens[s]) vv = adv(vv);
            t += lens[s];
            tog[s] = t;
        end
        // Final toggle and hold-counter load share an edge.
        done_at = tog[5] + 16;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("bnc_sw0",   32'(sw_out), 32'd1);
        check("bnc_busy0", 32'(busy),   32'd1);
        ntr = 1; last_change = 0; seg_idx = 0; prev = 1'b1;
        for (int j = 1; j <= done_at; j++) begin
            @(negedge clk);
            nt = 0;
            for (int s = 0; s < 6; s++) if (tog[s] <= j) nt++;
            exp_sw = ~nt[0];
            check("bnc_sw",   32'(sw_out), 32'(exp_sw));
            check("bnc_done", 32'(done),   32'(j == done_at));
            if (sw_out !== prev) begin
                ntr++;
                if (seg_idx < 6) check("bnc_seg_len", 32'(j - last_change), 32'(lens[seg_idx]));
                check("bnc_seg_max", 32'((j - last_change) <= 4), 32'd1);
                last_change = j;
                seg_idx++;
                prev = sw_out;
            end
        end
        check("bnc_transitions", 32'(ntr),       32'd7);
        check("bnc_final_sw",    32'(sw_out),    32'd1);
        check("bnc_ready",       32'(cmd_ready), 32'd1);

        // Async reset during BOUNCE while sw_out is high
        cmd_valid = 1'b1; cmd_level = 1'b0; bounce_num = 4'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        w = 0;
        while (!(sw_out === 1'b1 && busy === 1'b1) && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("mid_reach", 32'(w < 20), 32'd1);
        check("mid_state", 32'(dut.state_q), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_sw",    32'(sw_out),    32'd0);
        check("mid_ready", 32'(cmd_ready), 32'd1);
        check("mid_busy",  32'(busy),      32'd0);
        check("mid_state_idle", 32'(dut.state_q), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Closed loop with the debouncer model
        db_tog  = 0;
        db_prev = db_level;
        for (int i = 0; i < 20; i++) begin
            lvl = (i % 2 == 0);
            cmd_valid = 1'b1; cmd_level = lvl; bounce_num = 4'((i % 15) + 1);
            @(negedge clk);
            cmd_valid = 1'b0;
            w = 0;
            while (done !== 1'b1 && w < 300) begin
                @(negedge clk);
                w++;
                if (db_level !== db_prev) begin
                    db_tog++;
                    check("loop_db_in_settle", 32'(dut.state_q), 32'd2);
                    db_prev = db_level;
                end
            end
            check("loop_timeout",  32'(w < 300),  32'd1);
            check("loop_db_level", 32'(db_level), 32'(lvl));
        end
        check("loop_db_toggles", 32'(db_tog), 32'd20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
